pc_gen_unit: RTL and testbench
==============================

// Module: pc_gen_unit
// PURPOSE
//  Parametrised program-counter generator for the RV32I fetch stage. Holds the architectural PC and
//  issues fetch requests over a valid/ready handshake. Computes branch, JAL and JALR targets
//  internally (PC-relative add or (rs1+imm)&~1) and redirects on request. Detects misaligned targets
//  and vectors to a trap address. Replaces the stand-alone combinational PC+imm adder.
// PARAMETERS
//  XLEN          32             datapath/address width (bits)
//  RESET_VECTOR  32'h0100_0000  PC loaded on reset
//  TRAP_VECTOR   32'h0100_0040  PC loaded on misaligned-target trap
//  INC           4              sequential increment in bytes; also the alignment granule (power of 2)
// PORTS
//  clk          in   1     system clock, rising edge
//  rst          in   1     synchronous, active-high reset
//  fetch_ready  in   1     instruction memory accepts the current pc this cycle
//  redir_valid  in   1     execute stage requests redirect (taken branch / JAL / JALR)
//  redir_mode   in   1     0 = PC-relative (pc_base+imm); 1 = register (rs1+imm)&~1
//  pc_base      in   XLEN  PC of the redirecting instruction
//  rs1          in   XLEN  rs1 operand for JALR
//  imm          in   XLEN  sign-extended immediate
//  pc           out  XLEN  current fetch address (registered)
//  pc_plus      out  XLEN  pc+INC, combinational from pc (link value source)
//  fetch_valid  out  1     pc is a valid fetch request
//  trap         out  1     one-cycle pulse: misaligned redirect target detected
//  epc          out  XLEN  pc_base of the faulting instruction (held until next trap)
//  bad_addr     out  XLEN  faulting target address (held until next trap)
// BEHAVIOUR
//  Reset (rst=1 at posedge): pc=RESET_VECTOR, fetch_valid=0, trap=0, epc=0, bad_addr=0, state=BOOT.
//    rst=1 mid-operation overrides every other input in that cycle.
//  Target: tgt = mode0 ? pc_base+imm : (rs1+imm) & ~1. Arithmetic is modulo 2^XLEN (wrap, no flag).
//  misaligned = tgt[log2(INC)-1:0] != 0 (bit 0 is already cleared in mode 1).
//  FSM states: BOOT, RUN, TRAP.
//   BOOT: fetch_valid=0. Next state RUN; pc unchanged. First request is RESET_VECTOR, 1 cycle after reset.
//   RUN: fetch_valid=1. Priority per cycle: redirect-misaligned > redirect > accept > hold.
//    redir_valid & misaligned: pc<=TRAP_VECTOR, epc<=pc_base, bad_addr<=tgt, trap=1 next cycle,
//      state<=TRAP.
//    redir_valid & aligned: pc<=tgt; stays RUN; the current request is abandoned even if fetch_ready=1.
//    fetch_ready & !redir_valid: pc<=pc+INC (wraps at 2^XLEN).
//    otherwise: pc, fetch_valid held stable (handshake rule: a request changes only on accept,
//      redirect or reset).
//   TRAP: fetch_valid=0, trap=1 (registered pulse, exactly one cycle); redir_valid and fetch_ready
//      are ignored. Next state RUN; TRAP_VECTOR is issued the following cycle.
//  redir_valid in BOOT or TRAP is dropped (upstream flushes on trap); no internal queuing.
//  Latency: redirect -> pc=tgt with fetch_valid=1 on the next cycle (1-cycle bubble-free redirect).
//  Outputs except pc_plus are registered; pc_plus = pc+INC combinational.
// STRUCTURE
//  Shared package rv32_pkg: XLEN, RESET_VECTOR, TRAP_VECTOR defaults, localparam INC_BYTES=4,
//    redir_mode encodings (REDIR_PCREL=1'b0, REDIR_REG=1'b1), and the state enum
//    (PCG_BOOT, PCG_RUN, PCG_TRAP).
//  One sub-module: pc_target_calc (combinational: mode mux, adder, LSB clear, misaligned flag).
//  The state register, pc register and trap-capture registers stay in pc_gen_unit.
// TESTING
//  1 Reset then fetch_ready=1 for 4 cycles -> cycle1 fetch_valid=0; then pc 0x01000000, 0x01000004,
//    0x01000008.
//  2 Backpressure: fetch_ready=0 for 3 cycles at pc=0x01000008 -> pc, fetch_valid stable;
//    fetch_ready=1 -> pc=0x0100000C.
//  3 PC-relative redirect: pc_base=0x01000010, imm=-16 -> next pc=0x01000000;
//    wrap case pc_base=0xFFFFFFFC, imm=8 -> pc=0x00000004.
//  4 JALR: rs1=0x01000101, imm=2, mode=1 -> tgt 0x01000102 misaligned -> trap pulse 1 cycle,
//    epc=pc_base, bad_addr=0x01000102, next request pc=0x01000040.
//  5 Simultaneous: redir_valid=1 and fetch_ready=1 -> redirect wins, no pc+INC;
//    redir_valid during TRAP -> ignored.
//  6 rst asserted while in TRAP with redir_valid=1 -> all outputs at reset values next cycle, state BOOT.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32I fetch-stage constants, redirect encodings and PC generator state type.
package rv32_pkg;

    localparam int unsigned XLEN         = 32;
    localparam logic [31:0] RESET_VECTOR = 32'h0100_0000;
    localparam logic [31:0] TRAP_VECTOR  = 32'h0100_0040;
    localparam int unsigned INC_BYTES    = 4;

    localparam logic REDIR_PCREL = 1'b0;
    localparam logic REDIR_REG   = 1'b1;

    typedef enum logic [1:0] {
        PCG_BOOT,
        PCG_RUN,
        PCG_TRAP
    } pcg_state_e;

endpackage

// File: rtl/pc_target_calc.sv
// Redirect target calculation: PC-relative or register-based add, JALR LSB clear, alignment check.
module pc_target_calc #(
    parameter int unsigned XLEN = rv32_pkg::XLEN,
    parameter int unsigned INC  = rv32_pkg::INC_BYTES
) (
    input  logic            mode,
    input  logic [XLEN-1:0] pc_base,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] tgt_c,
    output logic            misaligned_c
);
    import rv32_pkg::*;

    logic [XLEN-1:0] base;
    logic [XLEN-1:0] sum;

    // Select the addend base, add the immediate modulo 2^XLEN, clear bit 0 for JALR.
    always_comb begin
        base  = (mode == REDIR_REG) ? rs1 : pc_base;
        sum   = base + imm;
        tgt_c = (mode == REDIR_REG) ? {sum[XLEN-1:1], 1'b0} : sum;
    end

    // Any set bit below the fetch granule makes the target unusable.
    assign misaligned_c = |(tgt_c & XLEN'(INC - 1));

endmodule

// File: rtl/pc_gen_unit.sv
// RV32I fetch program-counter generator with redirect and misaligned-target trap.
module pc_gen_unit #(
    parameter int unsigned     XLEN         = rv32_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(rv32_pkg::RESET_VECTOR),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(rv32_pkg::TRAP_VECTOR),
    parameter int unsigned     INC          = rv32_pkg::INC_BYTES
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_ready,
    input  logic            redir_valid,
    input  logic            redir_mode,
    input  logic [XLEN-1:0] pc_base,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus,
    output logic            fetch_valid,
    output logic            trap,
    output logic [XLEN-1:0] epc,
    output logic [XLEN-1:0] bad_addr
);
    import rv32_pkg::*;

    pcg_state_e      state;
    logic [XLEN-1:0] tgt;
    logic            misaligned;

    pc_target_calc #(
        .XLEN (XLEN),
        .INC  (INC)
    ) u_target (
        .mode         (redir_mode),
        .pc_base      (pc_base),
        .rs1          (rs1),
        .imm          (imm),
        .tgt_c        (tgt),
        .misaligned_c (misaligned)
    );

    // Link value source: next sequential address.
    assign pc_plus = pc + XLEN'(INC);

    // Fetch sequencing FSM with registered pc, request valid, trap pulse and trap capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= PCG_BOOT;
            pc          <= RESET_VECTOR;
            fetch_valid <= 1'b0;
            trap        <= 1'b0;
            epc         <= '0;
            bad_addr    <= '0;
        end else begin
            case (state)
                PCG_BOOT: begin
                    state       <= PCG_RUN;
                    fetch_valid <= 1'b1;
                    trap        <= 1'b0;
                end
                PCG_RUN: begin
                    trap <= 1'b0;
                    if (redir_valid && misaligned) begin
                        state       <= PCG_TRAP;
                        pc          <= TRAP_VECTOR;
                        fetch_valid <= 1'b0;
                        trap        <= 1'b1;
                        epc         <= pc_base;
                        bad_addr    <= tgt;
                    end else if (redir_valid) begin
                        pc <= tgt;
                    end else if (fetch_ready) begin
                        pc <= pc + XLEN'(INC);
                    end
                end
                PCG_TRAP: begin
                    state       <= PCG_RUN;
                    fetch_valid <= 1'b1;
                    trap        <= 1'b0;
                end
                default: begin
                    state       <= PCG_BOOT;
                    pc          <= RESET_VECTOR;
                    fetch_valid <= 1'b0;
                    trap        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_gen_unit.sv
// Self-checking bench for pc_gen_unit: reference model plus directed literal expectations.
module tb_pc_gen_unit;

    localparam logic [31:0] RV = 32'h0100_0000;
    localparam logic [31:0] TV = 32'h0100_0040;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_ready;
    logic        redir_valid;
    logic        redir_mode;
    logic [31:0] pc_base;
    logic [31:0] rs1;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pc_plus;
    logic        fetch_valid;
    logic        trap;
    logic [31:0] epc;
    logic [31:0] bad_addr;

    int n_vec = 0;
    int n_err = 0;

    pc_gen_unit dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_ready (fetch_ready),
        .redir_valid (redir_valid),
        .redir_mode  (redir_mode),
        .pc_base     (pc_base),
        .rs1         (rs1),
        .imm         (imm),
        .pc          (pc),
        .pc_plus     (pc_plus),
        .fetch_valid (fetch_valid),
        .trap        (trap),
        .epc         (epc),
        .bad_addr    (bad_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%08h, want 0x%08h", name, $time, act, exp);
        end
    endtask

    // Reference model: architectural view of the fetch PC, one update per rising edge.
    bit          armed = 1'b0;
    logic [31:0] m_pc, m_epc, m_bad;
    bit          m_valid, m_trap;

    always @(posedge clk) begin
        logic [31:0] t;
        if (rst) begin
            armed   = 1'b1;
            m_pc    = RV;
            m_valid = 1'b0;
            m_trap  = 1'b0;
            m_epc   = 32'd0;
            m_bad   = 32'd0;
        end else if (armed) begin
            if (!m_valid) begin
                // Bubble after reset or trap: the held pc is issued next, inputs ignored.
                m_valid = 1'b1;
                m_trap  = 1'b0;
            end else if (redir_valid) begin
                if (redir_mode) t = (rs1 + imm) & 32'hFFFF_FFFE;
                else            t = pc_base + imm;
                if ((t % 32'd4) != 32'd0) begin
                    m_pc    = TV;
                    m_valid = 1'b0;
                    m_trap  = 1'b1;
                    m_epc   = pc_base;
                    m_bad   = t;
                end else begin
                    m_pc = t;
                end
            end else if (fetch_ready) begin
                m_pc = m_pc + 32'd4;
            end
        end
    end

    // Compare every output against the model on each falling edge once reset has been seen.
    always @(negedge clk) begin
        if (armed) begin
            chk("pc",          pc,                  m_pc);
            chk("pc_plus",     pc_plus,             m_pc + 32'd4);
            chk("fetch_valid", 32'(fetch_valid),    32'(m_valid));
            chk("trap",        32'(trap),           32'(m_trap));
            chk("epc",         epc,                 m_epc);
            chk("bad_addr",    bad_addr,            m_bad);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic redir(input logic mode, input logic [31:0] base, input logic [31:0] r,
                         input logic [31:0] im);
        redir_valid = 1'b1;
        redir_mode  = mode;
        pc_base     = base;
        rs1         = r;
        imm         = im;
    endtask

    initial begin
        rst = 1'b1; fetch_ready = 1'b0; redir_valid = 1'b0; redir_mode = 1'b0;
        pc_base = '0; rs1 = '0; imm = '0;
        tick(); tick();
        chk("rst_pc", pc, RV);
        chk("rst_fv", 32'(fetch_valid), 32'd0);
        chk("rst_epc", epc, 32'd0);
        chk("rst_bad", bad_addr, 32'd0);

        // Boot and sequential fetch.
        rst = 1'b0; fetch_ready = 1'b1;
        tick(); chk("boot_pc", pc, 32'h0100_0000); chk("boot_fv", 32'(fetch_valid), 32'd1);
        tick(); chk("seq_pc1", pc, 32'h0100_0004);
        tick(); chk("seq_pc2", pc, 32'h0100_0008);

        // Backpressure holds the request.
        fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); chk("hold_pc", pc, 32'h0100_0008); chk("hold_fv", 32'(fetch_valid), 32'd1);
        end
        fetch_ready = 1'b1;
        tick(); chk("accept_pc", pc, 32'h0100_000C);
        fetch_ready = 1'b0;

        // PC-relative redirects, including wrap and redirect winning over accept.
        redir(1'b0, 32'h0100_0010, 32'd0, 32'hFFFF_FFF0);
        tick(); chk("pcrel_pc", pc, 32'h0100_0000);
        redir(1'b0, 32'hFFFF_FFFC, 32'd0, 32'd8); fetch_ready = 1'b1;
        tick(); chk("wrap_redir_pc", pc, 32'h0000_0004);
        fetch_ready = 1'b0;
        redir(1'b0, 32'hFFFF_FFF0, 32'd0, 32'h0000_000C);
        tick(); chk("top_pc", pc, 32'hFFFF_FFFC); chk("top_pc_plus", pc_plus, 32'h0000_0000);
        redir_valid = 1'b0; fetch_ready = 1'b1;
        tick(); chk("wrap_seq_pc", pc, 32'h0000_0000);
        fetch_ready = 1'b0;

        // JALR with bit 0 cleared before the alignment check.
        redir(1'b1, 32'h0000_0000, 32'h0100_0105, 32'd0);
        tick(); chk("jalr_pc", pc, 32'h0100_0104);

        // Misaligned JALR target traps; redirect during TRAP is ignored.
        redir(1'b1, 32'h0100_0020, 32'h0100_0101, 32'd2); fetch_ready = 1'b1;
        tick();
        chk("trap_pulse", 32'(trap), 32'd1); chk("trap_fv", 32'(fetch_valid), 32'd0);
        chk("trap_epc", epc, 32'h0100_0020); chk("trap_bad", bad_addr, 32'h0100_0102);
        redir(1'b1, 32'h0100_0020, 32'h0200_0000, 32'd0);
        tick();
        chk("trap_end", 32'(trap), 32'd0); chk("tv_pc", pc, TV);
        chk("tv_fv", 32'(fetch_valid), 32'd1); chk("trap_epc_held", epc, 32'h0100_0020);
        redir_valid = 1'b0;
        tick(); chk("after_tv_pc", pc, 32'h0100_0044);
        fetch_ready = 1'b0;

        // Misaligned PC-relative target, then reset while in TRAP with a redirect pending.
        redir(1'b0, 32'h0100_0050, 32'd0, 32'd2);
        tick(); chk("trap2_pulse", 32'(trap), 32'd1); chk("trap2_bad", bad_addr, 32'h0100_0052);
        rst = 1'b1; redir(1'b0, 32'h0200_0000, 32'd0, 32'd0);
        tick();
        chk("rst2_pc", pc, RV); chk("rst2_trap", 32'(trap), 32'd0);
        chk("rst2_fv", 32'(fetch_valid), 32'd0); chk("rst2_epc", epc, 32'd0);
        chk("rst2_bad", bad_addr, 32'd0);
        rst = 1'b0;
        tick(); chk("boot_drop_pc", pc, RV); chk("boot_drop_fv", 32'(fetch_valid), 32'd1);
        redir_valid = 1'b0;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
